// File: rtl/axis_eth_fcs_check_pkg.sv
// Shared constants and types for the Ethernet FCS checker.
package axis_eth_fcs_check_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned FCS_LEN     = 4;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Residue left by running the CRC over payload plus a correct FCS.
  localparam logic [31:0] CRC_RESIDUE = 32'h2144DF1C;
  localparam logic [2:0]  FILL_FULL   = 3'd4;

  // One beat handed from the frame logic to the output stage.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              user;
  } beat_t;

endpackage

// File: rtl/axis_eth_fcs_check_if.sv
// Byte-wide AXI4-Stream bundle with source (master) and sink (slave) views.
interface axis_eth_fcs_check_if;
  import axis_eth_fcs_check_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/axis_eth_fcs_check_lfsr.sv
// Combinational LFSR/CRC step: advances the state by DATA_WIDTH input bits.
module axis_eth_fcs_check_lfsr #(
  parameter int unsigned               LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0]     LFSR_POLY  = 32'h04C11DB7,
  parameter bit                        REVERSE    = 1'b1,
  parameter int unsigned               DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [LFSR_WIDTH-1:0] i_state,
  output logic [LFSR_WIDTH-1:0] o_state
);

  // Bit-reverse used to build the reflected polynomial at elaboration.
  function automatic logic [LFSR_WIDTH-1:0] reverse_bits(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] v_in;
    logic [LFSR_WIDTH-1:0] v_out;
    v_in  = v;
    v_out = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      v_out = {v_out[LFSR_WIDTH-2:0], v_in[0]};
      v_in  = v_in >> 1;
    end
    return v_out;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_REV = reverse_bits(LFSR_POLY);

  // Galois update, one data bit per iteration (LSB first when reflected).
  always_comb begin
    logic [LFSR_WIDTH-1:0] v_state;
    logic [DATA_WIDTH-1:0] v_data;
    logic                  v_fb;
    v_state = i_state;
    v_data  = i_data;
    v_fb    = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        v_fb    = v_state[0] ^ v_data[0];
        v_state = {1'b0, v_state[LFSR_WIDTH-1:1]} ^ (v_fb ? POLY_REV : '0);
        v_data  = v_data >> 1;
      end else begin
        v_fb    = v_state[LFSR_WIDTH-1] ^ v_data[DATA_WIDTH-1];
        v_state = {v_state[LFSR_WIDTH-2:0], 1'b0} ^ (v_fb ? LFSR_POLY : '0);
        v_data  = v_data << 1;
      end
    end
    o_state = v_state;
  end

endmodule

// File: rtl/axis_eth_fcs_check.sv
// Ethernet FCS checker: strips the trailing 4-byte FCS, verifies CRC-32 and
// flags bad or runt frames on m_axis.tuser, with one-cycle status pulses.
module axis_eth_fcs_check
  import axis_eth_fcs_check_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  axis_eth_fcs_check_if.slave         s_axis,
  axis_eth_fcs_check_if.master        m_axis,
  output logic                        busy,
  output logic                        error_bad_frame,
  output logic                        error_bad_fcs
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0][7:0]   r_dly;          // [0] newest .. [3] oldest
  logic [3:0][7:0]   w_dly_next;
  logic [2:0]        r_fill;
  logic [2:0]        w_fill_next;
  logic [31:0]       r_crc;
  logic [31:0]       w_crc_next;
  logic              r_busy;
  logic              w_busy_next;
  logic              r_err_frame;
  logic              w_err_frame_next;
  logic              r_err_fcs;
  logic              w_err_fcs_next;

  logic [31:0]       w_crc_step;
  logic [31:0]       w_fcs;
  logic              w_bad_fcs;
  logic              w_accept;
  beat_t             w_int;

  // Output register plus one-entry skid register.
  beat_t             r_out;
  beat_t             w_out_next;
  beat_t             r_tmp;
  beat_t             w_tmp_next;
  logic              r_tready_int;
  logic              w_tready_early;

  axis_eth_fcs_check_lfsr #(
    .LFSR_WIDTH (32),
    .LFSR_POLY  (CRC_POLY),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) u_crc_step (
    .i_data  (r_dly[3]),
    .i_state (r_crc),
    .o_state (w_crc_step)
  );

  assign w_accept  = s_axis.tvalid & r_tready_int;
  // Received FCS is little-endian on the wire; the byte arriving with tlast is the MSB.
  assign w_fcs     = {s_axis.tdata, r_dly[0], r_dly[1], r_dly[2]};
  assign w_bad_fcs = (w_fcs != ~w_crc_step);

  // Frame state register, delay line, CRC accumulator and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_dly       <= 32'h0000_0000;
      r_fill      <= 3'd0;
      r_crc       <= CRC_INIT;
      r_busy      <= 1'b0;
      r_err_frame <= 1'b0;
      r_err_fcs   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_dly       <= w_dly_next;
      r_fill      <= w_fill_next;
      r_crc       <= w_crc_next;
      r_busy      <= w_busy_next;
      r_err_frame <= w_err_frame_next;
      r_err_fcs   <= w_err_fcs_next;
    end
  end

  // Next-state logic: fill the delay line, then stream the oldest byte out.
  always_comb begin
    w_state_next     = r_state;
    w_dly_next       = r_dly;
    w_fill_next      = r_fill;
    w_crc_next       = r_crc;
    w_busy_next      = r_busy;
    w_err_frame_next = 1'b0;
    w_err_fcs_next   = 1'b0;
    w_int            = '{valid: 1'b0, data: 8'h00, last: 1'b0, user: 1'b0};
    if (w_accept) begin
      w_busy_next = 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (s_axis.tlast) begin
            // Too short to hold an FCS: emit a single poisoned beat.
            w_int            = '{valid: 1'b1, data: 8'h00, last: 1'b1, user: 1'b1};
            w_err_frame_next = 1'b1;
            w_fill_next      = 3'd0;
            w_crc_next       = CRC_INIT;
            w_busy_next      = 1'b0;
            w_state_next     = ST_IDLE;
          end else begin
            w_dly_next  = {r_dly[2:0], s_axis.tdata};
            w_fill_next = r_fill + 3'd1;
            if (r_fill == 3'd3) begin
              w_state_next = ST_PAYLOAD;
            end else begin
              w_state_next = ST_IDLE;
            end
          end
        end
        ST_PAYLOAD: begin
          if (s_axis.tlast) begin
            w_int            = '{valid: 1'b1, data: r_dly[3], last: 1'b1,
                                 user: s_axis.tuser | w_bad_fcs};
            w_err_frame_next = s_axis.tuser | w_bad_fcs;
            w_err_fcs_next   = w_bad_fcs;
            w_fill_next      = 3'd0;
            w_crc_next       = CRC_INIT;
            w_busy_next      = 1'b0;
            w_state_next     = ST_IDLE;
          end else begin
            w_int        = '{valid: 1'b1, data: r_dly[3], last: 1'b0, user: 1'b0};
            w_crc_next   = w_crc_step;
            w_dly_next   = {r_dly[2:0], s_axis.tdata};
            w_fill_next  = FILL_FULL;
            w_state_next = ST_PAYLOAD;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_fill_next  = 3'd0;
          w_crc_next   = CRC_INIT;
        end
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Input may be accepted next cycle if the skid slot is free and at most one beat is held.
  assign w_tready_early = m_axis.tready | (~r_tmp.valid & (~r_out.valid | ~w_int.valid));

  // Output stage steering between internal beat, skid register and output register.
  always_comb begin
    w_out_next = r_out;
    w_tmp_next = r_tmp;
    if (r_tready_int) begin
      if (m_axis.tready | ~r_out.valid) begin
        w_out_next = w_int;
      end else begin
        w_tmp_next = w_int;
      end
    end else if (m_axis.tready) begin
      w_out_next       = r_tmp;
      w_tmp_next.valid = 1'b0;
    end else begin
      w_out_next = r_out;
    end
  end

  // Output and skid registers plus the registered input ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '{valid: 1'b0, data: 8'h00, last: 1'b0, user: 1'b0};
      r_tmp        <= '{valid: 1'b0, data: 8'h00, last: 1'b0, user: 1'b0};
      r_tready_int <= 1'b0;
    end else begin
      r_out        <= w_out_next;
      r_tmp        <= w_tmp_next;
      r_tready_int <= w_tready_early;
    end
  end

  assign s_axis.tready   = r_tready_int;
  assign m_axis.tdata    = r_out.data;
  assign m_axis.tvalid   = r_out.valid;
  assign m_axis.tlast    = r_out.last;
  assign m_axis.tuser    = r_out.user;
  assign busy            = r_busy;
  assign error_bad_frame = r_err_frame;
  assign error_bad_fcs   = r_err_fcs;

endmodule
